// File: rtl/bg_pkg.sv
// Shared types and frame geometry for the background model updater.
// The pixel type and the default frame size live here so the memory side can reuse them.
package bg_pkg;

    localparam int unsigned NUM_PIXELS = 76800;
    localparam int unsigned ADDR_W     = 17;

    // Element [2] is R, [1] is G, [0] is B.
    typedef logic [2:0][7:0] rgb_t;

    typedef enum logic [1:0] {
        StIdle,
        StWaitSof,
        StRun
    } state_e;

endpackage

// File: rtl/bg_channel_blend.sv
// One colour channel of the running-average update: new = bg + (cur - bg) >>> ALPHA_SHIFT,
// or a straight copy of cur while the model is still learning.
module bg_channel_blend #(
    parameter int unsigned ALPHA_SHIFT = 3
) (
    input  logic [7:0] cur_i,
    input  logic [7:0] bg_i,
    input  logic       learn_i,
    output logic [7:0] new_o
);

    logic signed [8:0] diff;
    logic signed [8:0] delta;

    always_comb begin
        diff  = $signed({1'b0, cur_i}) - $signed({1'b0, bg_i});
        delta = diff >>> ALPHA_SHIFT;
        // The result always lands between bg and cur, so dropping the top bit is exact.
        new_o = learn_i ? cur_i : 8'({1'b0, bg_i} + delta);
    end

endmodule

// File: rtl/background_updater.sv
// Streams camera pixels through a read-blend-write loop against an external background memory,
// with a fixed 3-cycle acceptance-to-write latency and an initial copy-through learning phase.
module background_updater #(
    parameter int unsigned NUM_PIXELS   = bg_pkg::NUM_PIXELS,
    parameter int unsigned ADDR_W       = bg_pkg::ADDR_W,
    parameter int unsigned ALPHA_SHIFT  = 3,
    parameter int unsigned LEARN_FRAMES = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic                pix_valid,
    output logic                pix_ready,
    input  logic                pix_sof,
    input  bg_pkg::rgb_t        pix_rgb,
    input  logic                pix_fg,
    output logic                bg_rd_en,
    output logic [ADDR_W-1:0]   bg_rd_addr,
    input  bg_pkg::rgb_t        bg_rd_data,
    output logic                bg_wr_en,
    output logic [ADDR_W-1:0]   bg_wr_addr,
    output bg_pkg::rgb_t        bg_wr_data,
    output logic                learning,
    output logic                frame_done
);

    localparam int unsigned       CntW     = (LEARN_FRAMES > 0) ? $clog2(LEARN_FRAMES + 1) : 1;
    localparam logic [CntW-1:0]   LearnMax = CntW'(LEARN_FRAMES);
    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(NUM_PIXELS - 1);

    bg_pkg::state_e state_q, state_d;

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CntW-1:0]   frame_cnt_q, frame_cnt_d;

    logic              accept;
    logic              take;
    logic              pix_last;
    logic [ADDR_W-1:0] pix_addr;

    // Stage 1: read issued. Stage 2: read data returns. Write stage: registered outputs.
    logic              s1_valid_q, s1_valid_d;
    logic [ADDR_W-1:0] s1_addr_q, s1_addr_d;
    bg_pkg::rgb_t      s1_rgb_q, s1_rgb_d;
    logic              s1_fg_q, s1_fg_d;
    logic              s1_learn_q, s1_learn_d;
    logic              s1_last_q, s1_last_d;

    logic              s2_valid_q, s2_valid_d;
    logic [ADDR_W-1:0] s2_addr_q, s2_addr_d;
    bg_pkg::rgb_t      s2_rgb_q, s2_rgb_d;
    logic              s2_fg_q, s2_fg_d;
    logic              s2_learn_q, s2_learn_d;
    logic              s2_last_q, s2_last_d;

    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    bg_pkg::rgb_t      wr_data_q, wr_data_d;
    logic              done_q, done_d;

    logic [7:0]        blend_ch [3];

    // A pixel gets a memory slot only if it starts a frame or arrives while a frame is running.
    always_comb begin
        accept   = pix_valid & pix_ready;
        take     = accept & (pix_sof | (state_q == bg_pkg::StRun));
        pix_addr = pix_sof ? '0 : addr_q;
        pix_last = (pix_addr == LastAddr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= bg_pkg::StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            bg_pkg::StIdle: begin
                state_d = bg_pkg::StWaitSof;
            end
            bg_pkg::StWaitSof: begin
                if (take) state_d = pix_last ? bg_pkg::StWaitSof : bg_pkg::StRun;
            end
            bg_pkg::StRun: begin
                if (take && pix_last) state_d = bg_pkg::StWaitSof;
            end
            default: begin
                state_d = bg_pkg::StIdle;
            end
        endcase
        if (!enable) state_d = bg_pkg::StIdle;
    end

    // Gating with enable means no pixel is taken in the cycle enable drops.
    always_comb begin
        pix_ready = 1'b0;
        unique case (state_q)
            bg_pkg::StWaitSof,
            bg_pkg::StRun:  pix_ready = enable;
            default:        pix_ready = 1'b0;
        endcase
    end

    for (genvar i = 0; i < 3; i++) begin : g_chan
        bg_channel_blend #(
            .ALPHA_SHIFT (ALPHA_SHIFT)
        ) u_blend (
            .cur_i   (s2_rgb_q[i]),
            .bg_i    (bg_rd_data[i]),
            .learn_i (s2_learn_q),
            .new_o   (blend_ch[i])
        );
    end

    always_comb begin
        learning = (frame_cnt_q < LearnMax);

        addr_d = addr_q;
        if (take) addr_d = pix_last ? '0 : pix_addr + ADDR_W'(1);

        s1_valid_d = take;
        s1_addr_d  = s1_addr_q;
        s1_rgb_d   = s1_rgb_q;
        s1_fg_d    = s1_fg_q;
        s1_learn_d = s1_learn_q;
        s1_last_d  = s1_last_q;
        if (take) begin
            s1_addr_d  = pix_addr;
            s1_rgb_d   = pix_rgb;
            s1_fg_d    = pix_fg;
            s1_learn_d = learning;
            s1_last_d  = pix_last;
        end

        s2_valid_d = s1_valid_q;
        s2_addr_d  = s1_addr_q;
        s2_rgb_d   = s1_rgb_q;
        s2_fg_d    = s1_fg_q;
        s2_learn_d = s1_learn_q;
        s2_last_d  = s1_last_q;

        // Foreground pixels keep their slot (and frame_done) but leave memory untouched.
        wr_en_d   = s2_valid_q & (s2_learn_q | ~s2_fg_q);
        done_d    = s2_valid_q & s2_last_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (s2_valid_q) begin
            wr_addr_d = s2_addr_q;
            for (int i = 0; i < 3; i++) wr_data_d[i] = blend_ch[i];
        end

        frame_cnt_d = frame_cnt_q;
        if (done_d && (frame_cnt_q < LearnMax)) frame_cnt_d = frame_cnt_q + CntW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q      <= '0;
            frame_cnt_q <= '0;
            s1_valid_q  <= 1'b0;
            s1_addr_q   <= '0;
            s1_rgb_q    <= '0;
            s1_fg_q     <= 1'b0;
            s1_learn_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            s2_valid_q  <= 1'b0;
            s2_addr_q   <= '0;
            s2_rgb_q    <= '0;
            s2_fg_q     <= 1'b0;
            s2_learn_q  <= 1'b0;
            s2_last_q   <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            done_q      <= 1'b0;
        end else begin
            addr_q      <= addr_d;
            frame_cnt_q <= frame_cnt_d;
            s1_valid_q  <= s1_valid_d;
            s1_addr_q   <= s1_addr_d;
            s1_rgb_q    <= s1_rgb_d;
            s1_fg_q     <= s1_fg_d;
            s1_learn_q  <= s1_learn_d;
            s1_last_q   <= s1_last_d;
            s2_valid_q  <= s2_valid_d;
            s2_addr_q   <= s2_addr_d;
            s2_rgb_q    <= s2_rgb_d;
            s2_fg_q     <= s2_fg_d;
            s2_learn_q  <= s2_learn_d;
            s2_last_q   <= s2_last_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        bg_rd_en   = s1_valid_q;
        bg_rd_addr = s1_addr_q;
        bg_wr_en   = wr_en_q;
        bg_wr_addr = wr_addr_q;
        bg_wr_data = wr_data_q;
        frame_done = done_q;
    end

endmodule

// File: tb/tb_background_updater.sv
// Directed bench for background_updater on an 8-pixel frame: stimulus pushes expected reads,
// writes and frame_done pulses into queues; a negedge monitor pops and compares them.
module tb_background_updater;

    localparam int unsigned NP = 8;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        pix_valid;
    logic        pix_ready;
    logic        pix_sof;
    logic [23:0] pix_rgb;
    logic        pix_fg;
    logic        bg_rd_en;
    logic [16:0] bg_rd_addr;
    logic [23:0] bg_rd_data;
    logic        bg_wr_en;
    logic [16:0] bg_wr_addr;
    logic [23:0] bg_wr_data;
    logic        learning;
    logic        frame_done;

    typedef struct {
        logic [16:0] addr;
        logic [23:0] data;
        int          cyc;
    } ev_t;

    ev_t         rd_q [$];
    ev_t         wr_q [$];
    int          fd_q [$];
    ev_t         me;
    logic [23:0] mem [NP];
    int          cyc   = 0;
    int          total = 0;
    int          bad   = 0;

    background_updater #(
        .NUM_PIXELS   (NP),
        .ADDR_W       (17),
        .ALPHA_SHIFT  (3),
        .LEARN_FRAMES (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .pix_sof    (pix_sof),
        .pix_rgb    (pix_rgb),
        .pix_fg     (pix_fg),
        .bg_rd_en   (bg_rd_en),
        .bg_rd_addr (bg_rd_addr),
        .bg_rd_data (bg_rd_data),
        .bg_wr_en   (bg_wr_en),
        .bg_wr_addr (bg_wr_addr),
        .bg_wr_data (bg_wr_data),
        .learning   (learning),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Background memory: one-cycle read latency.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bg_rd_en) bg_rd_data <= mem[bg_rd_addr[2:0]];
        if (bg_wr_en) mem[bg_wr_addr[2:0]] <= bg_wr_data;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (rd_q.size() > 0 && rd_q[0].cyc == cyc && !bg_rd_en) check("rd_missing", bg_rd_en, 1);
            if (bg_rd_en) begin
                if (rd_q.size() == 0) begin
                    check("rd_unexpected", bg_rd_en, 0);
                end else begin
                    me = rd_q.pop_front();
                    check("rd_addr", bg_rd_addr, me.addr);
                    check("rd_cycle", cyc, me.cyc);
                end
            end
            if (wr_q.size() > 0 && wr_q[0].cyc == cyc && !bg_wr_en) check("wr_missing", bg_wr_en, 1);
            if (bg_wr_en) begin
                if (wr_q.size() == 0) begin
                    check("wr_unexpected", bg_wr_en, 0);
                end else begin
                    me = wr_q.pop_front();
                    check("wr_addr", bg_wr_addr, me.addr);
                    check("wr_data", bg_wr_data, me.data);
                    check("wr_cycle", cyc, me.cyc);
                end
            end
            if (fd_q.size() > 0 && fd_q[0] == cyc && !frame_done) check("fd_missing", frame_done, 1);
            if (frame_done) begin
                if (fd_q.size() == 0) begin
                    check("fd_unexpected", frame_done, 0);
                end else begin
                    check("fd_cycle", cyc, fd_q.pop_front());
                    check("fd_addr", bg_wr_addr, NP - 1);
                end
            end
        end
    end

    // addr < 0: pixel must be dropped. Read lands 1 cycle and write 3 cycles after acceptance.
    task automatic send(input logic sof, input logic [23:0] rgb, input logic fg, input int addr,
                        input bit do_wr, input logic [23:0] wdata);
        @(negedge clk);
        check("pix_ready", pix_ready, 1);
        pix_valid = 1'b1;
        pix_sof   = sof;
        pix_rgb   = rgb;
        pix_fg    = fg;
        if (addr >= 0) begin
            rd_q.push_back('{addr: 17'(addr), data: 24'h0, cyc: cyc + 1});
            if (do_wr) wr_q.push_back('{addr: 17'(addr), data: wdata, cyc: cyc + 3});
            if (addr == NP - 1) fd_q.push_back(cyc + 3);
        end
    endtask

    task automatic learn_pix(input logic sof, input int addr, input logic [23:0] rgb, input logic fg);
        send(sof, rgb, fg, addr, 1'b1, rgb);
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_pix_ready"}, pix_ready, 0);
        check({tag, "_rd_en"}, bg_rd_en, 0);
        check({tag, "_wr_en"}, bg_wr_en, 0);
        check({tag, "_frame_done"}, frame_done, 0);
        check({tag, "_rd_addr"}, bg_rd_addr, 0);
        check({tag, "_wr_addr"}, bg_wr_addr, 0);
        check({tag, "_wr_data"}, bg_wr_data, 0);
        check({tag, "_learning"}, learning, 1);
    endtask

    initial begin
        rst_n     = 1'b0;
        enable    = 1'b1;
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
        pix_rgb   = '0;
        pix_fg    = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_wait_sof", pix_ready, 1);
        send(1'b0, 24'h010203, 1'b0, -1, 1'b0, 24'h0);

        // Frame 0: learning copies cur even for foreground; two trailing pixels are dropped.
        learn_pix(1'b1, 0, {8'd10, 8'd20, 8'd30}, 1'b1);
        for (int k = 1; k < 8; k++) learn_pix(1'b0, k, {8'(k), 8'(2 * k), 8'(3 * k)}, k[0]);
        send(1'b0, 24'haaaaaa, 1'b0, -1, 1'b0, 24'h0);
        send(1'b0, 24'h555555, 1'b0, -1, 1'b0, 24'h0);
        idle(4);

        // Frame 1: sof in the sixth slot restarts at address 0.
        learn_pix(1'b1, 0, 24'h111111, 1'b0);
        for (int k = 1; k < 5; k++) learn_pix(1'b0, k, {8'(k + 40), 8'(k + 41), 8'(k + 42)}, 1'b0);
        learn_pix(1'b1, 0, 24'h222222, 1'b1);
        for (int k = 1; k < 8; k++) learn_pix(1'b0, k, {8'(k + 60), 8'(k + 70), 8'(k + 80)}, 1'b0);
        idle(4);

        // Frame 2.
        for (int k = 0; k < 8; k++) learn_pix(k == 0, k, {8'(k + 5), 8'(k + 6), 8'(k + 7)}, 1'b1);
        idle(6);
        check("learning_after_3_frames", learning, 1);

        // Frame 3 seeds the values used by the blend checks.
        learn_pix(1'b1, 0, {8'd100, 8'd100, 8'd255}, 1'b0);
        learn_pix(1'b0, 1, {8'd100, 8'd100, 8'd100}, 1'b1);
        for (int k = 2; k < 8; k++) learn_pix(1'b0, k, {8'd50, 8'd60, 8'd70}, 1'b0);
        idle(6);
        check("learning_after_4_frames", learning, 0);

        // Frame 4: blending, with address 2 flagged foreground.
        send(1'b1, {8'd180, 8'd20, 8'd0}, 1'b0, 0, 1'b1, {8'd110, 8'd90, 8'd223});
        send(1'b0, {8'd99, 8'd180, 8'd20}, 1'b0, 1, 1'b1, {8'd99, 8'd110, 8'd90});
        send(1'b0, {8'd0, 8'd0, 8'd0}, 1'b1, 2, 1'b0, 24'h0);
        send(1'b0, {8'd58, 8'd44, 8'd70}, 1'b0, 3, 1'b1, {8'd51, 8'd58, 8'd70});
        for (int k = 4; k < 8; k++) send(1'b0, {8'd50, 8'd60, 8'd70}, 1'b0, k, 1'b1, {8'd50, 8'd60, 8'd70});
        idle(6);
        check("learning_stays_low", learning, 0);

        // Reset pulse one cycle after acceptance: the read shows, the write never does.
        send(1'b1, 24'h0c0d0e, 1'b0, 0, 1'b0, 24'h0);
        @(negedge clk);
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
        #1 rst_n  = 1'b0;
        #1 check_reset_outputs("midframe_reset");
        @(negedge clk);
        rst_n = 1'b1;
        idle(6);

        check("rd_queue_drained", rd_q.size(), 0);
        check("wr_queue_drained", wr_q.size(), 0);
        check("fd_queue_drained", fd_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
